// File: rtl/soc_defs_pkg.sv
// soc_defs: definitions shared by the boot loader, the instruction ROM and
// the SoC top level.
//   ROM_ADDR_W     - ROM word-address width (capacity 2**ROM_ADDR_W words)
//   SYNC_BYTE      - frame start marker for the boot loader
//   loader_state_t - rom_loader FSM state encoding
package soc_defs;

    localparam int         ROM_ADDR_W = 12;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        CSUM,
        DONE_WAIT,
        ERR
    } loader_state_t;

endpackage

// File: rtl/rom_loader_asm.sv
// rom_loader_asm: byte-to-word assembler for the boot loader.
// Packs four consecutive bytes into one little-endian 32-bit word and keeps a
// running XOR of every byte fed in.
//   clk, rst    - clock, asynchronous active-high reset
//   clear       - restart at byte 0 and zero the running XOR (frame start)
//   byte_valid  - byte_data is consumed this cycle
//   byte_data   - payload byte
//   word_ready  - combinational pulse: this byte completes a word
//   word_data   - completed word, valid while word_ready is high
//   csum        - XOR of all bytes consumed since the last clear
module rom_loader_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word_data,
    output logic [7:0]  csum
);

    logic [1:0]  byte_idx_reg;
    logic [7:0]  csum_reg;
    logic [23:0] lanes;

    // The fourth byte is never stored: it goes straight into the top lane
    // so the word is available in the same cycle it is accepted.
    assign word_ready = byte_valid && (byte_idx_reg == 2'd3);
    assign word_data  = {byte_data, lanes};
    assign csum       = csum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx_reg <= '0;
            csum_reg     <= '0;
        end else if (clear) begin
            byte_idx_reg <= '0;
            csum_reg     <= '0;
        end else if (byte_valid) begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
            csum_reg     <= csum_reg ^ byte_data;
        end
    end

    // Lower three byte lanes; lane gi holds byte gi of the current word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (byte_valid && (byte_idx_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign lanes[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot-time program loader for the instruction ROM.
// Frame format: SYNC_BYTE, count[7:0], count[15:8], count little-endian
// 32-bit words, then one checksum byte equal to the XOR of all payload bytes.
// Each word is written to the ROM at consecutive addresses from 0; the core
// is held in reset until a frame loads with a matching checksum.
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_data  - byte source; transfer when in_valid && in_ready
//   in_ready          - loader can take a byte
//   rom_we/rom_waddr/rom_wdata - ROM write port, one strobe per word
//   core_hold         - keeps the core in reset
//   load_done         - sticky: last frame loaded, checksum matched
//   load_err          - sticky: last frame aborted (size, checksum, timeout)
module rom_loader #(
    parameter int         ADDR_W    = soc_defs::ROM_ADDR_W,
    parameter int         TIMEOUT   = 1000000,
    parameter logic [7:0] SYNC_BYTE = soc_defs::SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    import soc_defs::*;

    localparam int          IW        = ADDR_W + 1;
    localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_COUNT = 17'(1) << ADDR_W;

    loader_state_t     state_reg;
    logic [7:0]        cnt_lo_reg;
    // One bit wider than the address so a full-ROM count terminates cleanly.
    logic [IW-1:0]     count_reg;
    logic [IW-1:0]     word_idx_reg;
    logic [IW-1:0]     word_idx_next;
    logic [IDLE_W-1:0] idle_cnt_reg;

    logic        accept;
    logic        in_frame;
    logic        timeout_hit;
    logic        asm_clear;
    logic        asm_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic [7:0]  csum;
    logic [16:0] count_full;

    assign accept        = in_valid && in_ready;
    assign in_frame      = state_reg inside {CNT_LO, CNT_HI, DATA, CSUM};
    assign timeout_hit   = (idle_cnt_reg == IDLE_W'(TIMEOUT - 1));
    assign asm_clear     = accept && (state_reg == IDLE) && (in_data == SYNC_BYTE);
    assign asm_valid     = accept && (state_reg == DATA);
    assign word_idx_next = word_idx_reg + IW'(1);
    assign count_full    = {1'b0, in_data, cnt_lo_reg};

    rom_loader_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word_ready (word_ready),
        .word_data  (word_data),
        .csum       (csum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_lo_reg   <= '0;
            count_reg    <= '0;
            word_idx_reg <= '0;
            idle_cnt_reg <= '0;
            in_ready     <= 1'b0;
            rom_we       <= 1'b0;
            rom_waddr    <= '0;
            rom_wdata    <= '0;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            rom_we   <= 1'b0;
            in_ready <= 1'b1;

            if (in_frame && !accept) begin
                // Stalled inside a frame: abort once the source has been
                // silent for TIMEOUT clocks. A partial word is dropped.
                if (timeout_hit) begin
                    idle_cnt_reg <= '0;
                    state_reg    <= ERR;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                end
            end else begin
                if (accept) begin
                    idle_cnt_reg <= '0;
                end

                case (state_reg)
                    IDLE: begin
                        if (asm_clear) begin
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            core_hold <= 1'b1;
                            state_reg <= CNT_LO;
                        end
                    end
                    CNT_LO: begin
                        if (accept) begin
                            cnt_lo_reg <= in_data;
                            state_reg  <= CNT_HI;
                        end
                    end
                    CNT_HI: begin
                        if (accept) begin
                            word_idx_reg <= '0;
                            if (count_full > MAX_COUNT) begin
                                state_reg <= ERR;
                            end else begin
                                count_reg <= count_full[IW-1:0];
                                state_reg <= (count_full == '0) ? CSUM : DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (word_ready) begin
                            rom_we       <= 1'b1;
                            rom_waddr    <= word_idx_reg[ADDR_W-1:0];
                            rom_wdata    <= word_data;
                            word_idx_reg <= word_idx_next;
                            if (word_idx_next == count_reg) begin
                                state_reg <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (accept) begin
                            if (in_data == csum) begin
                                // Stall the source for one cycle so the last
                                // write lands before the core is released.
                                in_ready  <= 1'b0;
                                state_reg <= DONE_WAIT;
                            end else begin
                                state_reg <= ERR;
                            end
                        end
                    end
                    DONE_WAIT: begin
                        load_done <= 1'b1;
                        core_hold <= 1'b0;
                        state_reg <= IDLE;
                    end
                    ERR: begin
                        load_err  <= 1'b1;
                        core_hold <= 1'b1;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: self-checking bench for rom_loader.
// Frames are built from word lists; the expected ROM writes, checksum and
// final flags are derived from the frame rules (payload XOR, size limit,
// idle timeout) and compared against the DUT outputs.
module tb_rom_loader;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 64;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_err;

    int checks   = 0;
    int errors   = 0;
    int we_count = 0;
    int gap_max  = 2;
    bit exp_done = 1'b0;
    bit exp_err  = 1'b0;
    logic [31:0] payload[$];

    always #5 clk = ~clk;

    rom_loader #(
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // Every ROM write strobe is high for one cycle, so one count per strobe.
    always @(negedge clk) begin
        if (rom_we === 1'b1) we_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns 1 time unit after the edge
    // that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        wait_cycles(int'($urandom_range(0, gap_max)));
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_flags(input string tag, input bit done, input bit err, input bit hold);
        check({tag, "/load_done"}, 32'(load_done), 32'(done));
        check({tag, "/load_err"},  32'(load_err),  32'(err));
        check({tag, "/core_hold"}, 32'(core_hold), 32'(hold));
    endtask

    // Sends a whole frame of cnt words from payload; csum_force < 0 sends the
    // correct checksum, otherwise that byte value.
    task automatic run_frame(input logic [15:0] cnt, input int csum_force, input string name);
        logic [7:0]  cs;
        logic [7:0]  by;
        logic [7:0]  sent;
        logic [31:0] w;
        int          base;
        bit          good;
        cs   = 8'h00;
        base = we_count;
        send_byte(8'hA5);
        check_flags({name, "/sync"}, 1'b0, 1'b0, 1'b1);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (int'(cnt) > DEPTH) begin
            wait_cycles(4);
            check_flags({name, "/size"}, 1'b0, 1'b1, 1'b1);
            check({name, "/writes"}, 32'(we_count - base), 32'd0);
            exp_done = 1'b0;
            exp_err  = 1'b1;
            $display("frame %s count=%0d rejected as oversize", name, cnt);
            return;
        end
        for (int i = 0; i < int'(cnt); i++) begin
            w = payload[i];
            for (int b = 0; b < 4; b++) begin
                by = 8'(w >> (8 * b));
                cs = cs ^ by;
                send_byte(by);
                check({name, "/rom_we"}, 32'(rom_we), 32'(b == 3));
                if (b == 3) begin
                    check({name, "/rom_waddr"}, 32'(rom_waddr), 32'(i));
                    check({name, "/rom_wdata"}, rom_wdata, w);
                end
            end
        end
        sent = (csum_force < 0) ? cs : 8'(csum_force);
        good = (sent == cs);
        send_byte(sent);
        check({name, "/ready_after_csum"}, 32'(in_ready), 32'(!good));
        wait_cycles(3);
        check_flags({name, "/end"}, good, !good, !good);
        check({name, "/writes"}, 32'(we_count - base), 32'(cnt));
        exp_done = good;
        exp_err  = !good;
        $display("frame %s count=%0d csum_exp=%02h csum_sent=%02h done=%0b err=%0b writes=%0d",
                 name, cnt, cs, sent, load_done, load_err, we_count - base);
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/in_ready"},  32'(in_ready),  32'd0);
        check({tag, "/rom_we"},    32'(rom_we),    32'd0);
        check({tag, "/rom_waddr"}, 32'(rom_waddr), 32'd0);
        check({tag, "/rom_wdata"}, rom_wdata,      32'd0);
        check_flags(tag, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        int n;
        int force_cs;
        logic [7:0] garbage [3];

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Two-word frame with the correct checksum, then with a bad one.
        payload.delete();
        payload.push_back(32'h00100013);
        payload.push_back(32'h00200093);
        run_frame(16'd2, -1, "two_words");
        run_frame(16'd2, 0, "two_words_badcsum");

        // Non-sync bytes in IDLE are dropped without touching anything.
        garbage[0] = 8'h00;
        garbage[1] = 8'hFF;
        garbage[2] = 8'h12;
        base = we_count;
        for (int i = 0; i < 3; i++) send_byte(garbage[i]);
        wait_cycles(2);
        check("garbage/writes", 32'(we_count - base), 32'd0);
        check_flags("garbage", exp_done, exp_err, !exp_done);
        $display("garbage 00 FF 12 sent writes=%0d", we_count - base);
        run_frame(16'd2, -1, "after_garbage");

        // Empty frame and an oversize count.
        payload.delete();
        run_frame(16'd0, -1, "empty");
        run_frame(16'h1001, -1, "oversize");

        // Source stops after two data bytes.
        fill_random(2);
        base = we_count;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(payload[0][7:0]);
        send_byte(payload[0][15:8]);
        wait_cycles(TIMEOUT + 5);
        check_flags("timeout", 1'b0, 1'b1, 1'b1);
        check("timeout/writes", 32'(we_count - base), 32'd0);
        exp_done = 1'b0;
        exp_err  = 1'b1;
        $display("timeout frame stalled after 2 data bytes err=%0b writes=%0d", load_err, we_count - base);
        fill_random(5);
        run_frame(16'd5, -1, "after_timeout");

        // Reset in the middle of the payload, then a clean reload.
        fill_random(3);
        base = we_count;
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h00);
        for (int b = 0; b < 5; b++) send_byte(8'(payload[b / 4] >> (8 * (b % 4))));
        check("midreset/writes_before", 32'(we_count - base), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset/first_cycle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("midreset/ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        $display("reset asserted mid-frame, outputs returned to reset values");
        run_frame(16'd3, -1, "after_reset");

        // Random frames, some with a corrupted checksum.
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 24));
            fill_random(n);
            force_cs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_frame(16'(n), force_cs, $sformatf("rand%0d", k));
        end

        // Full ROM: count equal to the capacity must end without wrapping.
        gap_max = 0;
        fill_random(DEPTH);
        run_frame(16'(DEPTH), -1, "full_rom");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
